// File: rtl/counter_arb_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the
// counter arbiter block.
package counter_arb_pkg;

  localparam int NUM_REQ       = 4;
  localparam int IDX_W         = 2;
  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/counter_arb_ctrl_rr_arbiter4.sv
// Combinational round-robin winner selection over four requesters; the
// search starts one past the previous winner.
module rr_arbiter4
  import counter_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = last_winner;
    valid  = 1'b0;
    idx    = '0;
    // Offset NUM_REQ wraps back to last_winner, so it is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_winner + IDX_W'(k);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arb_ctrl.sv
// Four per-requester counters sharing one ripple-carry incrementer under a
// round-robin IDLE/GRANT/UPDATE FSM. Define CNT_SATURATE_EN to hold at all-ones.
module counter_arb_ctrl
  import counter_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ*CNT_W-1:0] count,
  output logic [NUM_REQ-1:0]       wrap,
  output logic                     busy
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] winner_reg, winner_next;
  logic [IDX_W-1:0] last_winner_reg;
  logic             wrap_reg;

  logic [IDX_W-1:0] arb_winner;
  logic             arb_valid;

  logic [CNT_W-1:0] add_a, add_sum, cnt_wr;
  logic [CNT_W:0]   carry;
  logic             commit;

  rr_arbiter4 u_arb (
    .req         (req),
    .last_winner (last_winner_reg),
    .winner      (arb_winner),
    .valid       (arb_valid)
  );

  // Single shared incrementer, operand muxed from the current winner.
  assign add_a    = count[int'(winner_reg)*CNT_W +: CNT_W];
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_inc
      assign add_sum[gi]   = add_a[gi] ^ carry[gi];
      assign carry[gi+1]   = add_a[gi] & carry[gi];
    end
  endgenerate

`ifdef CNT_SATURATE_EN
  assign cnt_wr = carry[CNT_W] ? add_a : add_sum;
`else
  assign cnt_wr = add_sum;
`endif

  // Count is written on the GRANT->UPDATE edge so it is visible during UPDATE.
  assign commit = (state_reg == GRANT) && req[winner_reg];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          cnt_reg <= '0;
        else if (commit && (winner_reg == IDX_W'(gi)))
          cnt_reg <= cnt_wr;
      end
      assign count[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      winner_reg      <= '0;
      last_winner_reg <= IDX_W'(NUM_REQ - 1);
      wrap_reg        <= 1'b0;
    end else begin
      state_reg  <= state_next;
      winner_reg <= winner_next;
      if (commit)
        wrap_reg <= carry[CNT_W];
      if (state_reg == UPDATE)
        last_winner_reg <= winner_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    winner_next = winner_reg;
    gnt         = '0;
    done        = '0;
    wrap        = '0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          winner_next = arb_winner;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        gnt        = onehot(winner_reg);
        state_next = req[winner_reg] ? UPDATE : IDLE;
      end
      UPDATE: begin
        done       = onehot(winner_reg);
        wrap       = wrap_reg ? onehot(winner_reg) : '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Directed bench for counter_arb_ctrl: vector table plus hand-written
// sequences for wrap, abort, hold-off and mid-update reset.
module tb_counter_arb_ctrl;
  import counter_arb_pkg::*;

  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       req;
  logic [3:0]       gnt, done, wrap;
  logic [4*CW-1:0]  count;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  counter_arb_ctrl #(.CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .done    (done),
    .count   (count),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] count;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    tick();
    tick();
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_wrap",  32'(wrap),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_count", 32'(count), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles);
    bit found;
    found = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (done != 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
    check("done_timeout", 32'(found), 32'h1);
  endtask

  // Invariant monitor: one-hot outputs, done follows gnt, busy tracks FSM.
  logic [3:0] prev_gnt;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_gnt = 4'b0000;
    end else begin
      check("gnt_onehot0",    32'($onehot0(gnt)),  32'h1);
      check("done_onehot0",   32'($onehot0(done)), 32'h1);
      check("wrap_onehot0",   32'($onehot0(wrap)), 32'h1);
      check("done_after_gnt", 32'(done & ~prev_gnt), 32'h0);
      check("wrap_with_done", 32'(wrap & ~done),     32'h0);
      check("busy_state",     32'(busy), 32'((gnt != 4'b0000) || (done != 4'b0000)));
      prev_gnt = gnt;
    end
  end

  initial begin
    int exp_c;
    logic [3:0] exp_w;

    reset_n = 1'b0;
    req     = 4'b0000;

    // req, gnt, done, busy, count after the following posedge
    vecs[0]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 16'h0000};
    vecs[1]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 16'h0001};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0001};
    vecs[3]  = '{4'b1111, 4'b0010, 4'b0000, 1'b1, 16'h0001};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0010, 1'b1, 16'h0011};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 16'h0011};
    vecs[6]  = '{4'b1111, 4'b0100, 4'b0000, 1'b1, 16'h0011};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0100, 1'b1, 16'h0111};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 16'h0111};
    vecs[9]  = '{4'b1111, 4'b1000, 4'b0000, 1'b1, 16'h0111};
    vecs[10] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 16'h1111};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 16'h1111};
    vecs[12] = '{4'b1111, 4'b0001, 4'b0000, 1'b1, 16'h1111};
    vecs[13] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 16'h1112};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h1112};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vecs[i].gnt));
      check($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].done));
      check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].count));
      check($sformatf("vec%0d_wrap", i),  32'(wrap),  32'h0);
      $display("vec %0d req=%b gnt=%b done=%b busy=%b count=%h", i, req, gnt, done, busy, count);
    end

    // Sixteen increments of requester 0: wraps (or saturates) on the last.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      wait_done(6);
`ifdef CNT_SATURATE_EN
      exp_c = (i + 1 > 15) ? 15 : i + 1;
`else
      exp_c = (i + 1) % 16;
`endif
      exp_w = (i == 15) ? 4'b0001 : 4'b0000;
      check($sformatf("wrap_seq%0d_count", i), 32'(count[3:0]), 32'(exp_c));
      check($sformatf("wrap_seq%0d_done", i),  32'(done),        32'h1);
      check($sformatf("wrap_seq%0d_wrap", i),  32'(wrap),        32'(exp_w));
      $display("wrap seq %0d count0=%0d wrap=%b", i, count[3:0], wrap);
    end

    // Request dropped during GRANT aborts without moving the pointer.
    do_reset();
    req = 4'b0100;
    tick();
    check("abort_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    tick();
    check("abort_done",  32'(done),         32'h0);
    check("abort_busy",  32'(busy),         32'h0);
    check("abort_count", 32'(count[11:8]),  32'h0);
    req = 4'b0101;
    tick();
    check("abort_next_gnt", 32'(gnt), 32'b0001);
    $display("abort seq gnt=%b count=%h", gnt, count);
    tick();
    req = 4'b0000;
    tick();

    // Request raised during UPDATE waits for IDLE.
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    check("holdoff_done0", 32'(done), 32'b0001);
    req = 4'b0010;
    tick();
    check("holdoff_idle_gnt",  32'(gnt),  32'h0);
    check("holdoff_idle_busy", 32'(busy), 32'h0);
    tick();
    check("holdoff_gnt1", 32'(gnt), 32'b0010);
    $display("holdoff seq gnt=%b", gnt);
    tick();
    req = 4'b0000;
    tick();

    // Reset during UPDATE of requester 1 at count 5.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 5; i++) wait_done(6);
    check("midrst_pre_count", 32'(count[7:4]), 32'h5);
    reset_n = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_done",  32'(done),  32'h0);
    check("midrst_busy",  32'(busy),  32'h0);
    check("midrst_gnt",   32'(gnt),   32'h0);
    @(negedge clk);
    req     = 4'b0011;
    reset_n = 1'b1;
    tick();
    check("midrst_first_gnt", 32'(gnt),  32'b0001);
    check("midrst_no_done",   32'(done), 32'h0);
    $display("midreset seq gnt=%b count=%h", gnt, count);
    req = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
